// File: rtl/sd_pkg.sv
// Shared definitions for the SD write-path blocks: FSM states, block geometry
// and the CRC16-CCITT polynomial used on the SD data line.
package sd_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ARM   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } sd_state_e;

    localparam int          SD_BLK_BYTES  = 512;
    localparam logic [15:0] SD_CRC16_POLY = 16'h1021;
    localparam int          SD_CRC_BYTES  = 2;

endpackage

// File: rtl/sd_wr_buf_if.sv
// Bus between the user byte stream, the SD write engine and sd_wr_buf.
// Handshakes: a byte moves on wr_valid & wr_ready in the same cycle; upstream holds
// wr_data stable while wr_valid is high and wr_ready is low. rd_en is a request with
// no back-pressure; rd_vld answers it exactly one cycle later.
interface sd_wr_buf_if;
    import sd_pkg::*;

    logic       init_o;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       write_seq;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_vld;
    logic       rd_last;
    logic       blk_done;
    logic       busy;
    sd_state_e  dbg_state;

    modport master (
        output init_o, wr_valid, wr_data, rd_en, blk_done,
        input  wr_ready, write_seq, rd_data, rd_vld, rd_last, busy, dbg_state
    );

    modport slave (
        input  init_o, wr_valid, wr_data, rd_en, blk_done,
        output wr_ready, write_seq, rd_data, rd_vld, rd_last, busy, dbg_state
    );

endinterface

// File: rtl/sd_crc16.sv
// Combinational byte-wide CRC16-CCITT update (poly 0x1021, no reflection),
// bits consumed MSB-first as they leave on the SD data line.
import sd_pkg::*;

module sd_crc16 (
    input  logic [15:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_acc;
    logic        fb;

    always_comb begin
        crc_acc = crc_i;
        fb      = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            fb      = crc_acc[15] ^ data_i[i];
            crc_acc = {crc_acc[14:0], 1'b0} ^ (fb ? SD_CRC16_POLY : 16'h0000);
        end
    end

    assign crc_o = crc_acc;

endmodule

// File: rtl/sd_wr_buf.sv
// One-block write buffer in front of the SD write engine: fill, arm, drain payload
// plus two CRC bytes, hold until done. Define SD_WR_CRC16_EN for a real CRC16.
import sd_pkg::*;

module sd_wr_buf #(
    parameter int BLK_BYTES = SD_BLK_BYTES,
    parameter int AW        = $clog2(BLK_BYTES)
) (
    input  logic        SD_CK,
    input  logic        rst,
    sd_wr_buf_if.slave  bus
);

    localparam int RCNT_W = AW + 1;

    sd_state_e         state_q, state_d;
    logic [AW-1:0]     wcnt_q, wcnt_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic              wr_ready_q, wr_ready_d;
    logic              write_seq_q, write_seq_d;
    logic              rd_vld_q, rd_vld_d;
    logic              rd_last_q, rd_last_d;
    logic              busy_q, busy_d;
    logic [7:0]        byte_q, byte_d;
    logic              src_ram_q, src_ram_d;
    logic              blk_clr;
    logic              wr_ready;
    logic              wr_fire;
    logic              rd_fire;
    logic [15:0]       crc_word;

    logic [7:0]        ram [BLK_BYTES];
    logic [7:0]        ram_q;

    // Reset must win over a concurrent byte offer, so ready is masked combinationally.
    assign wr_ready = wr_ready_q & ~rst;
    assign wr_fire  = wr_ready & bus.wr_valid;
    assign rd_fire  = (state_q == ST_DRAIN) & bus.rd_en & ~bus.blk_done;

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        write_seq_d = 1'b0;
        rd_vld_d    = 1'b0;
        rd_last_d   = 1'b0;
        byte_d      = byte_q;
        src_ram_d   = src_ram_q;
        blk_clr     = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (wr_fire) begin
                    wcnt_d = wcnt_q + AW'(1);
                    if (wcnt_q == AW'(BLK_BYTES - 1)) state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (bus.init_o) begin
                    write_seq_d = 1'b1;
                    state_d     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.blk_done) begin
                    blk_clr = 1'b1;
                    state_d = ST_FILL;
                end else if (bus.rd_en) begin
                    rd_vld_d  = 1'b1;
                    rcnt_d    = rcnt_q + RCNT_W'(1);
                    // Top rcnt bit set means the payload is exhausted; even index is CRC high.
                    src_ram_d = ~rcnt_q[AW];
                    byte_d    = rcnt_q[0] ? crc_word[7:0] : crc_word[15:8];
                    if (rcnt_q == RCNT_W'(BLK_BYTES + SD_CRC_BYTES - 1)) begin
                        rd_last_d = 1'b1;
                        state_d   = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.blk_done) begin
                    blk_clr = 1'b1;
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase

        if (blk_clr) begin
            wcnt_d = '0;
            rcnt_d = '0;
        end
    end

    assign wr_ready_d = (state_d == ST_FILL);
    assign busy_d     = (state_d != ST_FILL);

    always_ff @(posedge SD_CK) begin
        if (rst) begin
            state_q     <= ST_FILL;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            wr_ready_q  <= 1'b1;
            write_seq_q <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
            busy_q      <= 1'b0;
            byte_q      <= 8'h00;
            src_ram_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            wr_ready_q  <= wr_ready_d;
            write_seq_q <= write_seq_d;
            rd_vld_q    <= rd_vld_d;
            rd_last_q   <= rd_last_d;
            busy_q      <= busy_d;
            byte_q      <= byte_d;
            src_ram_q   <= src_ram_d;
        end
    end

    // Single-port RAM: FILL writes and DRAIN reads never overlap.
    always_ff @(posedge SD_CK) begin
        if (wr_fire) ram[wcnt_q] <= bus.wr_data;
        if (rd_fire && !rcnt_q[AW]) ram_q <= ram[rcnt_q[AW-1:0]];
    end

`ifdef SD_WR_CRC16_EN
    logic [15:0] crc_q, crc_d, crc_upd;

    sd_crc16 u_crc16 (
        .crc_i  (crc_q),
        .data_i (bus.wr_data),
        .crc_o  (crc_upd)
    );

    always_comb begin
        crc_d = crc_q;
        if (blk_clr)      crc_d = '0;
        else if (wr_fire) crc_d = crc_upd;
    end

    always_ff @(posedge SD_CK) begin
        if (rst) crc_q <= '0;
        else     crc_q <= crc_d;
    end

    assign crc_word = crc_q;
`else
    // Card-side CRC checking disabled: both trailer bytes read back as 0xFF.
    assign crc_word = 16'hFFFF;
`endif

    assign bus.wr_ready  = wr_ready;
    assign bus.write_seq = write_seq_q;
    assign bus.rd_data   = src_ram_q ? ram_q : byte_q;
    assign bus.rd_vld    = rd_vld_q;
    assign bus.rd_last   = rd_last_q;
    assign bus.busy      = busy_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_sd_wr_buf.sv
// Directed bench for sd_wr_buf: fill/arm timing, drain order and CRC trailer,
// init gating, abort and mid-fill reset. Expected CRC follows SD_WR_CRC16_EN.
module tb_sd_wr_buf;
    import sd_pkg::*;

    localparam int BLK = SD_BLK_BYTES;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    sd_wr_buf_if bus();

    sd_wr_buf dut (
        .SD_CK (clk),
        .rst   (rst),
        .bus   (bus)
    );

    typedef struct {
        logic       init_o;
        logic       wr_valid;
        logic       rd_en;
        logic       blk_done;
        logic       e_wr_ready;
        logic       e_busy;
        logic       e_write_seq;
        logic       e_rd_vld;
        logic       chk_data;
        logic [7:0] e_rd_data;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pat_byte(input int pat, input int i);
        logic [31:0] v;
        case (pat)
            0:       v = 32'hFF;
            1:       v = i;
            2:       v = i + 3;
            3:       v = i * 7;
            default: v = i ^ 32'h5A;
        endcase
        return v[7:0];
    endfunction

    function automatic logic [15:0] crc_model(input int pat);
        logic [15:0] c = 16'h0000;
        logic [7:0]  b;
        for (int i = 0; i < BLK; i++) begin
            b = pat_byte(pat, i);
            for (int k = 7; k >= 0; k--) begin
                if (c[15] ^ b[k]) c = {c[14:0], 1'b0} ^ 16'h1021;
                else              c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    function automatic logic [15:0] exp_crc(input int pat);
`ifdef SD_WR_CRC16_EN
        return crc_model(pat);
`else
        return (pat >= 0) ? 16'hFFFF : 16'h0000;
`endif
    endfunction

    task automatic fill_block(input string name, input int pat);
        int stall = 0;
        for (int i = 0; i < BLK; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = pat_byte(pat, i);
            if (bus.wr_ready !== 1'b1) stall++;
            step();
        end
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        check({name, "_fill_ready"}, stall, 0);
    endtask

    task automatic wait_seq(input string name);
        int seen = 0;
        for (int c = 0; c < 8 && seen == 0; c++) begin
            step();
            if (bus.write_seq === 1'b1) seen = 1;
        end
        check({name, "_write_seq"}, seen, 1);
    endtask

    task automatic done_pulse(input string name);
        bus.blk_done = 1'b1;
        step();
        bus.blk_done = 1'b0;
        check({name, "_done_ready"}, bus.wr_ready, 1'b1);
        check({name, "_done_busy"}, bus.busy, 1'b0);
    endtask

    // Back-to-back rd_en well past the last byte; extra requests must yield no beats.
    task automatic drain_all(input string name, input int pat, input int start_idx,
                             input logic [15:0] exp_c);
        int         beats = 0;
        int         bad = 0;
        int         last_cnt = 0;
        int         last_idx = -1;
        int         idx;
        logic [7:0] hi = 8'h00;
        logic [7:0] lo = 8'h00;
        bus.rd_en = 1'b1;
        for (int c = 0; c < BLK + 20; c++) begin
            step();
            if (bus.rd_vld === 1'b1) begin
                idx = start_idx + beats;
                if (idx < BLK) begin
                    if (bus.rd_data !== pat_byte(pat, idx)) bad++;
                end else if (idx == BLK) begin
                    hi = bus.rd_data;
                end else begin
                    lo = bus.rd_data;
                end
                if (bus.rd_last === 1'b1) begin
                    last_cnt++;
                    last_idx = idx;
                end
                beats++;
            end
        end
        bus.rd_en = 1'b0;
        check({name, "_beats"}, beats, BLK + 2 - start_idx);
        check({name, "_data"}, bad, 0);
        check({name, "_crc_hi"}, hi, exp_c[15:8]);
        check({name, "_crc_lo"}, lo, exp_c[7:0]);
        check({name, "_last_cnt"}, last_cnt, 1);
        check({name, "_last_idx"}, last_idx, BLK + 1);
    endtask

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        int seen;
        int bad;
        int beats;

        // ARM-state vectors: stray inputs ignored, then init_o releases the block.
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01};

        rst          = 1'b1;
        bus.init_o   = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        bus.rd_en    = 1'b0;
        bus.blk_done = 1'b0;
        repeat (3) step();
        check("rst_wr_ready", bus.wr_ready, 1'b0);
        check("rst_write_seq", bus.write_seq, 1'b0);
        check("rst_rd_data", bus.rd_data, 8'h00);
        check("rst_rd_vld", bus.rd_vld, 1'b0);
        check("rst_rd_last", bus.rd_last, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_state", bus.dbg_state, ST_FILL);
        rst = 1'b0;
        step();
        check("rel_wr_ready", bus.wr_ready, 1'b1);

        // Fill 0xFF block with init high: exact write_seq timing.
        bus.init_o = 1'b1;
        fill_block("ff", 0);
        check("ff_arm_seq_early", bus.write_seq, 1'b0);
        check("ff_arm_wr_ready", bus.wr_ready, 1'b0);
        check("ff_arm_busy", bus.busy, 1'b1);
        step();
        check("ff_seq_pulse", bus.write_seq, 1'b1);
        check("ff_seq_busy", bus.busy, 1'b1);
        step();
        check("ff_seq_one_cycle", bus.write_seq, 1'b0);
`ifdef SD_WR_CRC16_EN
        drain_all("ff", 0, 0, 16'h7FA1);
`else
        drain_all("ff", 0, 0, 16'hFFFF);
`endif
        check("ff_hold_busy", bus.busy, 1'b1);
        check("ff_hold_wr_ready", bus.wr_ready, 1'b0);
        done_pulse("ff");

        // Init gating and data order.
        bus.init_o = 1'b0;
        fill_block("ord", 1);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (bus.write_seq !== 1'b0) seen++;
        end
        check("ord_gate_no_seq", seen, 0);
        for (int v = 0; v < 7; v++) begin
            bus.init_o   = vecs[v].init_o;
            bus.wr_valid = vecs[v].wr_valid;
            bus.wr_data  = 8'hC3;
            bus.rd_en    = vecs[v].rd_en;
            bus.blk_done = vecs[v].blk_done;
            step();
            check($sformatf("vec%0d_wr_ready", v), bus.wr_ready, vecs[v].e_wr_ready);
            check($sformatf("vec%0d_busy", v), bus.busy, vecs[v].e_busy);
            check($sformatf("vec%0d_write_seq", v), bus.write_seq, vecs[v].e_write_seq);
            check($sformatf("vec%0d_rd_vld", v), bus.rd_vld, vecs[v].e_rd_vld);
            check($sformatf("vec%0d_rd_last", v), bus.rd_last, 1'b0);
            if (vecs[v].chk_data)
                check($sformatf("vec%0d_rd_data", v), bus.rd_data, vecs[v].e_rd_data);
        end
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        bus.blk_done = 1'b0;
        drain_all("ord", 1, 2, exp_crc(1));
        done_pulse("ord");

        // Abort after 100 payload bytes, then a fresh block from index 0.
        bus.init_o = 1'b1;
        fill_block("ab", 2);
        wait_seq("ab");
        bad   = 0;
        beats = 0;
        bus.rd_en = 1'b1;
        for (int c = 0; c < 100; c++) begin
            step();
            if (bus.rd_vld === 1'b1) begin
                if (bus.rd_data !== pat_byte(2, beats)) bad++;
                beats++;
            end
        end
        bus.rd_en = 1'b0;
        check("ab_part_beats", beats, 100);
        check("ab_part_data", bad, 0);
        done_pulse("ab");
        fill_block("ab2", 3);
        wait_seq("ab2");
        drain_all("ab2", 3, 0, exp_crc(3));
        done_pulse("ab2");

        // Reset mid-fill with a byte on offer: reset wins, next block restarts cleanly.
        for (int i = 0; i < 37; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = pat_byte(2, i);
            step();
        end
        rst = 1'b1;
        step();
        check("mid_rst_wr_ready", bus.wr_ready, 1'b0);
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_write_seq", bus.write_seq, 1'b0);
        check("mid_rst_rd_vld", bus.rd_vld, 1'b0);
        check("mid_rst_rd_last", bus.rd_last, 1'b0);
        check("mid_rst_rd_data", bus.rd_data, 8'h00);
        rst          = 1'b0;
        bus.wr_valid = 1'b0;
        step();
        check("mid_rel_wr_ready", bus.wr_ready, 1'b1);
        fill_block("rst", 4);
        wait_seq("rst");
        drain_all("rst", 4, 0, exp_crc(4));
        done_pulse("rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
